muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multicycle multiply/divide unit that owns the HI/LO register pair for the MIPS core. The execute stage issues a single operation per request and stalls on `oBusy`. The unit answers with a one-cycle `oDone` pulse and exposes HI/LO continuously for MFHI/MFLO. It replaces single-cycle `*`, `/` and `%` with a 32-iteration shift-add / restoring-divide datapath.

## Interface
- Parameters: none. All datapath widths are fixed at 32 bits; HI/LO together are 64 bits.
- iCLK  in  1  system clock; all state changes on the rising edge.
- iRST  in  1  reset, asynchronous, active-low (0 = reset).
- iStart  in  1  request strobe; sampled only while `oBusy`=0.
- iOp  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU.
- iA  in  32  rs operand (multiplicand / dividend / MT source).
- iB  in  32  rt operand (multiplier / divisor).
- oBusy  out  1  high while an iterative operation is in flight.
- oDone  out  1  one-cycle pulse when an accepted operation has committed to HI/LO.
- oHI  out  32  architectural HI register.
- oLO  out  32  architectural LO register.
- oDivZero  out  1  valid with `oDone`: set to 1 when the committed DIV/DIVU had divisor 0; 0 for every other op.

## Operation
- **States:** IDLE, ITER, FIX.
- **Accept:** `iStart`=1 in IDLE. `iA`, `iB` and `iOp` are latched into internal registers, so the inputs may change afterwards.
- **MTHI / MTLO**
  - HI (or LO) is written with `iA` on the accept edge.
  - The FSM stays in IDLE and `oDone`=1 on the next cycle.
  - `oBusy` never rises.
- **MULT / MULTU / MADD / MADDU**
  - Accept moves the FSM to ITER, count=0.
  - Unsigned 32x32 shift-add on operand magnitudes (MULTU/MADDU use the raw operands) into a 64-bit internal product.
- **DIV / DIVU**
  - Accept moves the FSM to ITER.
  - Restoring division on magnitudes: 32 iterations, one quotient bit per cycle, 33-bit partial remainder.
- **ITER:** one iteration per cycle, count 0..31. When count=31 the next state is FIX.
- **FIX (one cycle), then back to IDLE. On the edge leaving FIX:**
  - Signed multiply: the product is negated if `iA[31]` != `iB[31]`.
  - MADD/MADDU: {HI,LO} <= {HI,LO} + product, mod 2^64.
  - MULT/MULTU: {HI,LO} <= product.
  - Signed divide: the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - LO <= quotient, HI <= remainder.
  - `oDone`=1 on the following cycle.
- **Divisor 0 (DIV or DIVU):** full latency is still spent. LO=32'hFFFFFFFF, HI=`iA` (unmodified dividend), `oDivZero`=1.
- **Overflow cases:** DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps). No trap is raised.
- **HI/LO visibility:** `oHI`/`oLO` hold their previous values throughout ITER/FIX; only the commit edge changes them.

## Timing
- **Reset values** (asserted asynchronously, held until `iRST` returns to 1):
  - `oBusy`=0, `oDone`=0, `oDivZero`=0, `oHI`=0, `oLO`=0.
  - FSM=IDLE, count=0, internal registers 0.
- **Reset mid-operation:** the operation is aborted. No commit and no `oDone` are produced after release.
- **Iterative ops**
  - Accept edge E0. `oBusy`=1 in the 33 cycles following E0 (32 ITER + 1 FIX).
  - HI/LO are updated at edge E33.
  - In the cycle after E33: `oBusy`=0 and `oDone`=1.
- **MT ops:** register updated at E0; `oDone`=1 in the cycle after E0.
- **Back-to-back requests:** a new `iStart` is accepted in the same cycle `oDone` is high, because `oBusy`=0 in that cycle.
- **Start while busy:** `iStart` while `oBusy`=1 is ignored. There is no queue and no effect on the running op.
- **oDone** is never high for more than one consecutive cycle per accepted request.
- **oDivZero** is registered alongside `oDone` and cleared on the next accept.

## Test plan
- **MULT sign handling:** MULT `iA`=0xFFFFFFFD (-3), `iB`=5 -> `oBusy` high exactly 33 cycles, then `oDone` pulse; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **DIV sign handling:** DIV `iA`=0xFFFFFFF9 (-7), `iB`=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, `oDivZero`=0; then DIVU on the same operands -> LO=0x7FFFFFFC, HI=1.
- **Divide by zero:** DIVU `iA`=0x80000000, `iB`=0 -> LO=0xFFFFFFFF, HI=0x80000000, `oDivZero`=1 with `oDone`, after 33 busy cycles.
- **MTHI + MADDU accumulate:** after reset, MTHI `iA`=1 -> `oDone` next cycle, HI=1, LO=0, `oBusy` stays 0. Then MADDU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFF, LO=0x00000001.
- **Start while busy:** MULT 7x6 accepted; pulse `iStart` with DIVU at busy cycle 10 -> ignored; HI=0, LO=42; exactly one `oDone`.
- **Reset mid-operation:** DIV in flight; drive `iRST`=0 at busy cycle 20 -> all outputs 0 immediately; after release, no `oDone`; a fresh MULT 2x3 then gives LO=6.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multicycle multiply/divide unit owning the HI/LO pair: 32-step shift-add multiply,
// 32-step restoring divide on magnitudes, sign fix-up and commit in a final FIX cycle.
module muldiv_unit (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iStart,
   input  logic [2:0]  iOp,
   input  logic [31:0] iA,
   input  logic [31:0] iB,
   output logic        oBusy,
   output logic        oDone,
   output logic [31:0] oHI,
   output logic [31:0] oLO,
   output logic        oDivZero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ITER = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   logic [1:0]  state;
   logic [4:0]  count;
   logic [2:0]  opReg;
   logic [31:0] aReg, bReg, magA, magB;
   logic [63:0] acc;

   logic        inSigned, opSigned, isDiv, isMadd, negate, divGeq, divZero;
   logic [31:0] inMagA, inMagB, divSub, quo, rem;
   logic [32:0] mulSum;
   logic [63:0] mulNext, divNext, mulProd, mulRes;

   // Odd opcodes (MULTU/DIVU/MADDU) are the unsigned variants.
   assign inSigned = ~iOp[0];
   assign inMagA   = (inSigned && iA[31]) ? -iA : iA;
   assign inMagB   = (inSigned && iB[31]) ? -iB : iB;

   assign opSigned = ~opReg[0];
   assign isDiv    = (opReg[2:1] == 2'b01);
   assign isMadd   = (opReg[2:1] == 2'b11);
   assign negate   = opSigned && (aReg[31] ^ bReg[31]);

   // acc = {partial product high, remaining multiplier bits}
   assign mulSum  = {1'b0, acc[63:32]} + {1'b0, magA};
   assign mulNext = acc[0] ? {mulSum, acc[31:1]} : {1'b0, acc[63:1]};

   // acc = {remainder, dividend/quotient}; the shifted remainder is 33 bits wide,
   // but when it is >= divisor the difference fits in 32 bits.
   assign divGeq  = (acc[63:31] >= {1'b0, magB});
   assign divSub  = acc[62:31] - magB;
   assign divNext = divGeq ? {divSub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

   assign mulProd = negate ? -acc : acc;
   assign mulRes  = isMadd ? ({oHI, oLO} + mulProd) : mulProd;
   assign quo     = negate ? -acc[31:0] : acc[31:0];
   assign rem     = (opSigned && aReg[31]) ? -acc[63:32] : acc[63:32];
   assign divZero = (bReg == 32'd0);

   assign oBusy = (state != IDLE);

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state    <= IDLE;
         count    <= 5'd0;
         opReg    <= 3'd0;
         aReg     <= 32'd0;
         bReg     <= 32'd0;
         magA     <= 32'd0;
         magB     <= 32'd0;
         acc      <= 64'd0;
         oDone    <= 1'b0;
         oDivZero <= 1'b0;
         oHI      <= 32'd0;
         oLO      <= 32'd0;
      end else begin
         oDone <= 1'b0;
         case (state)
            IDLE: if (iStart) begin
               opReg    <= iOp;
               aReg     <= iA;
               bReg     <= iB;
               oDivZero <= 1'b0;
               if (iOp == OP_MTHI) begin
                  oHI   <= iA;
                  oDone <= 1'b1;
               end else if (iOp == OP_MTLO) begin
                  oLO   <= iA;
                  oDone <= 1'b1;
               end else begin
                  magA  <= inMagA;
                  magB  <= inMagB;
                  acc   <= {32'd0, (iOp[2:1] == 2'b01) ? inMagA : inMagB};
                  count <= 5'd0;
                  state <= ITER;
               end
            end
            ITER: begin
               acc   <= isDiv ? divNext : mulNext;
               count <= count + 5'd1;
               if (count == 5'd31) state <= FIX;
            end
            FIX: begin
               state <= IDLE;
               oDone <= 1'b1;
               if (isDiv) begin
                  oDivZero <= divZero;
                  if (divZero) begin
                     oLO <= 32'hFFFF_FFFF;
                     oHI <= aReg;
                  end else begin
                     oLO <= quo;
                     oHI <= rem;
                  end
               end else begin
                  {oHI, oLO} <= mulRes;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push expected HI/LO/divzero from a
// plain-arithmetic model; a negedge monitor pops and compares on every oDone.
module tb_muldiv_unit;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic        iStart = 1'b0;
   logic [2:0]  iOp = 3'd0;
   logic [31:0] iA = 32'd0;
   logic [31:0] iB = 32'd0;
   logic        oBusy, oDone, oDivZero;
   logic [31:0] oHI, oLO;

   muldiv_unit dut (
      .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
      .oBusy(oBusy), .oDone(oDone), .oHI(oHI), .oLO(oLO), .oDivZero(oDivZero)
   );

   always #5 iCLK = ~iCLK;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t        expQ[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] hiM = 32'd0, loM = 32'd0, holdHi = 32'd0, holdLo = 32'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Architectural reference: MIPS HI/LO semantics via 64-bit integer arithmetic.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output exp_t e);
      longint      sa, sb, q, r;
      logic [63:0] acc, p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      acc = {hiM, loM};
      e.dz = 1'b0;
      case (op)
         3'd0: begin p = 64'(sa * sb); {hiM, loM} = p; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; {hiM, loM} = p; end
         3'd2: begin
            if (b == 32'd0) begin loM = 32'hFFFF_FFFF; hiM = a; e.dz = 1'b1; end
            else begin q = sa / sb; r = sa % sb; loM = q[31:0]; hiM = r[31:0]; end
         end
         3'd3: begin
            if (b == 32'd0) begin loM = 32'hFFFF_FFFF; hiM = a; e.dz = 1'b1; end
            else begin loM = a / b; hiM = a % b; end
         end
         3'd4: hiM = a;
         3'd5: loM = a;
         3'd6: begin p = acc + 64'(sa * sb); {hiM, loM} = p; end
         default: begin p = acc + {32'd0, a} * {32'd0, b}; {hiM, loM} = p; end
      endcase
      e.hi = hiM;
      e.lo = loM;
   endtask

   always @(negedge iCLK) begin : monitor
      exp_t e;
      if (iRST && oDone) begin
         if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_done: got oDone=1 expected no pending op");
         end else begin
            e = expQ.pop_front();
            check("hi", {32'd0, oHI}, {32'd0, e.hi});
            check("lo", {32'd0, oLO}, {32'd0, e.lo});
            check("divzero", {63'd0, oDivZero}, {63'd0, e.dz});
         end
      end
   end

   // Called at a negedge with the unit idle; returns just after the accept edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      holdHi = hiM;
      holdLo = loM;
      model(op, a, b, e);
      expQ.push_back(e);
      iStart = 1'b1; iOp = op; iA = a; iB = b;
      @(posedge iCLK);
      #1;
      iStart = 1'b0; iOp = 3'($urandom); iA = $urandom; iB = $urandom;
   endtask

   task automatic wait_idle(output int n);
      bit holdOk;
      holdOk = 1'b1;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge iCLK);
         if (!oBusy) break;
         n++;
         if (oHI !== holdHi || oLO !== holdLo) holdOk = 1'b0;
      end
      if (oBusy) begin
         tests++;
         fails++;
         $display("FAIL busy_timeout: got oBusy=1 after 100 cycles expected 0");
      end
      if (n > 0) check("hilo_hold", {63'd0, holdOk}, 64'd1);
   endtask

   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      issue(op, a, b);
      wait_idle(n);
      check("busy_cycles", 64'(n), (op[2:1] == 2'b10) ? 64'd0 : 64'd33);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int          n;
      logic [2:0]  op;
      logic [31:0] a, b;
      #12;
      check("reset_flags", {61'd0, oBusy, oDone, oDivZero}, 64'd0);
      check("reset_hilo", {oHI, oLO}, 64'd0);
      @(negedge iCLK);
      iRST = 1'b1;
      @(negedge iCLK);

      run(3'd4, 32'd1, 32'd0);
      check("mthi_hilo", {oHI, oLO}, 64'h00000001_00000000);
      run(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("maddu_hilo", {oHI, oLO}, 64'hFFFFFFFF_00000001);
      run(3'd0, 32'hFFFF_FFFD, 32'd5);
      check("mult_neg", {oHI, oLO}, 64'hFFFFFFFF_FFFFFFF1);
      run(3'd2, 32'hFFFF_FFF9, 32'd2);
      check("div_neg", {oHI, oLO}, 64'hFFFFFFFF_FFFFFFFD);
      run(3'd3, 32'hFFFF_FFF9, 32'd2);
      check("divu", {oHI, oLO}, 64'h00000001_7FFFFFFC);
      run(3'd3, 32'h8000_0000, 32'd0);
      check("divu_zero", {oHI, oLO}, 64'h80000000_FFFFFFFF);
      check("divzero_flag", {63'd0, oDivZero}, 64'd1);
      run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_ovf", {oHI, oLO}, 64'h00000000_80000000);
      run(3'd5, 32'h1234_5678, 32'd0);

      // A start while busy must be dropped without disturbing the running MULT.
      issue(3'd0, 32'd7, 32'd6);
      repeat (10) @(negedge iCLK);
      iStart = 1'b1; iOp = 3'd3; iA = 32'd100; iB = 32'd7;
      @(posedge iCLK);
      #1;
      iStart = 1'b0;
      wait_idle(n);
      check("busy_remaining", 64'(n), 64'd23);
      check("mult_ignored_start", {oHI, oLO}, 64'd42);
      repeat (5) @(negedge iCLK);

      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 7) == 1) a = 32'h8000_0000;
         if ($urandom_range(0, 7) == 2) b = 32'hFFFF_FFFF;
         run(op, a, b);
      end

      // Abort an in-flight DIV with reset.
      issue(3'd2, $urandom, 32'd5);
      repeat (20) @(negedge iCLK);
      iRST = 1'b0;
      #1;
      expQ.delete();
      hiM = 32'd0;
      loM = 32'd0;
      check("midreset_flags", {61'd0, oBusy, oDone, oDivZero}, 64'd0);
      check("midreset_hilo", {oHI, oLO}, 64'd0);
      repeat (2) @(negedge iCLK);
      iRST = 1'b1;
      repeat (40) @(negedge iCLK);
      check("post_reset_idle", {63'd0, oBusy}, 64'd0);
      run(3'd0, 32'd2, 32'd3);
      check("mult_after_reset", {oHI, oLO}, 64'd6);

      repeat (3) @(negedge iCLK);
      check("queue_empty", 64'(expQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
